// File: rtl/fir_coef_regbank.sv
// fir_coef_regbank: CDC-side register bank with shadow coefficients committed to a FIR core.
module fir_coef_regbank #(
    parameter int          NTAPS_MAX = 32,
    parameter logic [15:0] ID_VALUE  = 16'hF1A0
) (
    input  logic        clk_b,
    input  logic        rst_n,
    input  logic [5:0]  CDC_A,
    input  logic [15:0] CDC_data,
    input  logic        CDC_wr,
    output logic [15:0] data_back,
    input  logic        fir_busy,
    input  logic        coef_ready,
    output logic        coef_wr,
    output logic [4:0]  coef_addr,
    output logic [15:0] coef_data,
    output logic        fir_en,
    output logic [5:0]  ntaps_act
);
    localparam logic [5:0] NMAX = 6'(NTAPS_MAX);

    typedef enum logic [1:0] {IDLE, WAIT, LOAD, DONE} state_t;

    state_t      state_q;
    logic [15:0] shadow_q [NTAPS_MAX];
    logic [5:0]  ntaps_q, ntaps_act_q, load_cnt_q;
    logic [4:0]  idx_q;
    logic        enable_q, done_q, drop_q;
    logic [7:0]  cnt_q;
    logic [15:0] data_back_q;

    logic        busy, wr_ctrl, wr_stat, wr_ntaps, coef_hit, wr_coef, soft_clr, last;
    logic [5:0]  ntaps_d;
    logic [15:0] data_back_d;

    always_comb begin
        busy        = state_q != IDLE;
        wr_ctrl     = CDC_wr && CDC_A == 6'h00;
        wr_stat     = CDC_wr && CDC_A == 6'h01;
        wr_ntaps    = CDC_wr && CDC_A == 6'h02;
        coef_hit    = CDC_A[5] && {1'b0, CDC_A[4:0]} < NMAX;
        wr_coef     = CDC_wr && coef_hit;
        soft_clr    = wr_ctrl && CDC_data[2];
        last        = {1'b0, idx_q} == load_cnt_q - 6'd1;
        ntaps_d     = CDC_data == 16'd0 ? 6'd1 :
                      CDC_data > 16'(NTAPS_MAX) ? NMAX : CDC_data[5:0];
        data_back_d = CDC_A == 6'h00 ? {14'b0, enable_q, 1'b0} :
                      CDC_A == 6'h01 ? {cnt_q, 4'b0, drop_q, done_q, state_q == WAIT, busy} :
                      CDC_A == 6'h02 ? {10'b0, ntaps_q} :
                      CDC_A == 6'h03 ? ID_VALUE :
                      coef_hit ? shadow_q[CDC_A[4:0]] : 16'h0000;
    end

    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            for (int i = 0; i < NTAPS_MAX; i++) shadow_q[i] <= '0;
            ntaps_q     <= NMAX;
            ntaps_act_q <= NMAX;
            load_cnt_q  <= NMAX;
            idx_q       <= '0;
            enable_q    <= 1'b0;
            done_q      <= 1'b0;
            drop_q      <= 1'b0;
            cnt_q       <= '0;
            data_back_q <= '0;
        end else begin
            data_back_q <= data_back_d;
            if (wr_ctrl) enable_q <= CDC_data[1];
            if (wr_stat && CDC_data[2]) done_q <= 1'b0;
            if (wr_stat && CDC_data[3]) drop_q <= 1'b0;
            // Shadow and tap count are frozen while a commit is in flight
            if (busy && (wr_coef || wr_ntaps || soft_clr)) drop_q <= 1'b1;
            if (!busy && wr_ntaps) ntaps_q <= ntaps_d;
            if (!busy && wr_coef) shadow_q[CDC_A[4:0]] <= CDC_data;
            if (!busy && soft_clr)
                for (int i = 0; i < NTAPS_MAX; i++) shadow_q[i] <= '0;
            case (state_q)
                IDLE: if (wr_ctrl && CDC_data[0]) begin
                    state_q <= WAIT;
                    done_q  <= 1'b0;
                end
                WAIT: if (!fir_busy) begin
                    state_q    <= LOAD;
                    load_cnt_q <= ntaps_q;
                    idx_q      <= '0;
                end
                LOAD: if (coef_ready) begin
                    if (last) state_q <= DONE;
                    else idx_q <= idx_q + 5'd1;
                end
                DONE: begin
                    state_q     <= IDLE;
                    ntaps_act_q <= load_cnt_q;
                    done_q      <= 1'b1;
                    cnt_q       <= cnt_q + 8'd1;
                    idx_q       <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_back = data_back_q;
    assign coef_wr   = state_q == LOAD;
    assign coef_addr = idx_q;
    assign coef_data = shadow_q[idx_q];
    assign fir_en    = enable_q && state_q != LOAD;
    assign ntaps_act = ntaps_act_q;
endmodule

// File: tb/tb_fir_coef_regbank.sv
// tb_fir_coef_regbank: randomized register/commit checks against an array-based reference model.
module tb_fir_coef_regbank;
    logic        clk_b = 0, rst_n = 1;
    logic [5:0]  CDC_A = 0;
    logic [15:0] CDC_data = 0;
    logic        CDC_wr = 0, fir_busy = 0, coef_ready = 0;
    logic [15:0] data_back, coef_data;
    logic        coef_wr, fir_en;
    logic [4:0]  coef_addr;
    logic [5:0]  ntaps_act;

    fir_coef_regbank dut (
        .clk_b(clk_b), .rst_n(rst_n), .CDC_A(CDC_A), .CDC_data(CDC_data), .CDC_wr(CDC_wr),
        .data_back(data_back), .fir_busy(fir_busy), .coef_ready(coef_ready),
        .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
        .fir_en(fir_en), .ntaps_act(ntaps_act)
    );

    always #5 clk_b = ~clk_b;

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [15:0] m_sh [32];
    int          m_ntaps, m_act, m_cnt;
    bit          m_en, m_done, m_drop, m_busy;

    function automatic void m_reset();
        foreach (m_sh[i]) m_sh[i] = 0;
        m_ntaps = 32; m_act = 32; m_cnt = 0;
        m_en = 0; m_done = 0; m_drop = 0; m_busy = 0;
    endfunction

    function automatic void m_write(input int a, input logic [15:0] d);
        if (a == 0) begin
            m_en = d[1];
            if (d[0] && !m_busy) m_done = 0;
            if (d[2]) begin
                if (m_busy) m_drop = 1;
                else foreach (m_sh[i]) m_sh[i] = 0;
            end
        end else if (a == 1) begin
            if (d[2]) m_done = 0;
            if (d[3]) m_drop = 0;
        end else if (a == 2) begin
            if (m_busy) m_drop = 1;
            else m_ntaps = d == 0 ? 1 : (d > 32 ? 32 : int'(d));
        end else if (a >= 32) begin
            if (m_busy) m_drop = 1;
            else m_sh[a-32] = d;
        end
    endfunction

    function automatic logic [15:0] m_read(input int a);
        logic [7:0] c;
        c = m_cnt[7:0];
        if (a == 0) return {14'b0, m_en, 1'b0};
        if (a == 1) return {c, 4'b0, m_drop, m_done, 2'b00};
        if (a == 2) return 16'(m_ntaps);
        if (a == 3) return 16'hF1A0;
        if (a >= 32) return m_sh[a-32];
        return 16'h0;
    endfunction

    task automatic wr(input int a, input logic [15:0] d);
        CDC_A = a[5:0]; CDC_data = d; CDC_wr = 1;
        @(posedge clk_b); #1;
        CDC_wr = 0;
        m_write(a, d);
    endtask

    task automatic rdchk(input string tag, input int a);
        CDC_A = a[5:0]; CDC_wr = 0;
        @(posedge clk_b); #1;
        check(tag, data_back, m_read(a));
    endtask

    logic [20:0] xq[$];
    bit          st_prev = 0;
    logic [20:0] prev;

    always @(negedge clk_b) begin
        if (coef_wr) begin
            check("fir_en_masked", fir_en, 0);
            if (st_prev) check("xfer_hold", {coef_addr, coef_data}, prev);
            if (coef_ready) xq.push_back({coef_addr, coef_data});
        end
        st_prev = coef_wr && !coef_ready;
        prev = {coef_addr, coef_data};
    end

    // mode 0: coef_ready held, 1: toggles each cycle, 2: random
    task automatic wait_done(input string tag, input int mode);
        bit ok = 0;
        CDC_A = 6'h01; CDC_wr = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk_b); #1;
            if (mode == 1) coef_ready = ~coef_ready;
            if (mode == 2) coef_ready = 1'($urandom_range(0, 1));
            if (!data_back[0] && data_back[2]) begin ok = 1; break; end
        end
        check({tag, "_timeout"}, ok, 1);
        m_busy = 0; m_done = 1; m_cnt++; m_act = m_ntaps;
        check({tag, "_nxfer"}, xq.size(), m_ntaps);
        for (int k = 0; k < xq.size(); k++) begin
            check({tag, "_addr"}, xq[k][20:16], k);
            check({tag, "_data"}, xq[k][15:0], m_sh[k]);
        end
        check({tag, "_ntaps_act"}, ntaps_act, m_act);
        check({tag, "_fir_en"}, fir_en, m_en);
        rdchk({tag, "_status"}, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_back"}, data_back, 0);
        check({tag, "_coef_wr"}, coef_wr, 0);
        check({tag, "_coef_addr"}, coef_addr, 0);
        check({tag, "_coef_data"}, coef_data, 0);
        check({tag, "_fir_en"}, fir_en, 0);
        check({tag, "_ntaps_act"}, ntaps_act, 32);
    endtask

    initial begin
        logic [15:0] old;
        bit hit;
        m_reset();
        #1 rst_n = 0;
        #10 check_reset_outputs("rst");
        @(negedge clk_b) rst_n = 1;
        @(posedge clk_b); #1;

        wr(6'h20, 16'h1111);
        wr(6'h3F, 16'hBEEF);
        rdchk("rd_20", 6'h20);
        rdchk("rd_3f", 6'h3F);
        rdchk("rd_id", 6'h03);
        rdchk("rd_10", 6'h10);
        rdchk("rd_ntaps_rst", 6'h02);

        old = m_read(6'h25);
        CDC_A = 6'h25; CDC_data = 16'h1234; CDC_wr = 1;
        @(posedge clk_b); #1;
        CDC_wr = 0;
        check("raw_old", data_back, old);
        m_write(6'h25, 16'h1234);
        rdchk("raw_new", 6'h25);

        repeat (24) wr(32 + $urandom_range(0, 31), 16'($urandom));
        wr(6'h03, 16'($urandom));
        wr(6'h10, 16'($urandom));
        repeat (16) rdchk("rand_rd", $urandom_range(0, 63));

        wr(6'h02, 16'd0);  rdchk("ntaps_0", 2);
        wr(6'h02, 16'd40); rdchk("ntaps_40", 2);
        repeat (6) begin
            wr(6'h02, 16'($urandom_range(0, 70)));
            rdchk("ntaps_rand", 2);
        end

        wr(6'h00, 16'h0004);
        repeat (4) rdchk("soft_clr", 32 + $urandom_range(0, 31));
        for (int i = 0; i < 32; i++) wr(32 + i, 16'($urandom));

        wr(6'h02, 16'd4);
        xq.delete(); coef_ready = 0;
        wr(6'h00, 16'h0003); m_busy = 1;
        wait_done("bp", 1);
        check("bp_status_const", data_back, 16'h0104);

        wr(6'h02, 16'd8);
        xq.delete(); coef_ready = 0; fir_busy = 1;
        wr(6'h00, 16'h0001); m_busy = 1;
        CDC_A = 6'h01;
        repeat (10) begin
            @(posedge clk_b); #1;
            check("wait_coef_wr", coef_wr, 0);
            check("wait_pending", data_back[1:0], 2'b11);
        end
        fir_busy = 0;
        @(posedge clk_b); #1;
        check("load_start", coef_wr, 1);
        wr(6'h21, 16'hDEAD);
        wr(6'h02, 16'd5);
        wr(6'h00, 16'h0001);
        wr(6'h00, 16'h0006);
        check("en_masked_load", fir_en, 0);
        coef_ready = 1;
        wait_done("fb", 0);
        rdchk("drop_coef", 6'h21);
        rdchk("drop_ntaps", 6'h02);
        wr(6'h01, 16'h0008);
        rdchk("drop_clr", 1);
        wr(6'h01, 16'h0004);
        rdchk("done_clr", 1);

        repeat (3) begin
            for (int i = 0; i < 8; i++) wr(32 + $urandom_range(0, 31), 16'($urandom));
            wr(6'h02, 16'($urandom_range(1, 32)));
            xq.delete(); coef_ready = 0;
            wr(6'h00, 16'($urandom_range(0, 1) << 1) | 16'h1); m_busy = 1;
            wait_done("rand", 2);
        end

        wr(6'h02, 16'd8);
        xq.delete(); coef_ready = 1;
        wr(6'h00, 16'h0003); m_busy = 1;
        hit = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk_b); #1;
            if (coef_wr && coef_addr == 5'd2) begin hit = 1; break; end
        end
        check("mid_load_reach", hit, 1);
        #1 rst_n = 0;
        #1 check_reset_outputs("mid_rst");
        m_reset();
        @(negedge clk_b) rst_n = 1;
        repeat (3) begin
            @(posedge clk_b); #1;
            check("post_rst_coef_wr", coef_wr, 0);
        end
        rdchk("post_rst_status", 1);
        rdchk("post_rst_coef", 6'h20);
        check("post_rst_ntaps_act", ntaps_act, 32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
